// File: rtl/ssp.sv
// Synchronous serial port: byte-wide bus <-> TI-format serial link.
// 4-deep TX and RX FIFOs; transmit clock is PCLK/2, receive pins are sampled by PCLK.
module ssp (
    input  logic       PCLK,
    input  logic       CLEAR_B,
    input  logic       PSEL,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    input  logic       SSPCLKIN,
    input  logic       SSPFSSIN,
    input  logic       SSPRXD,
    output logic       SSPCLKOUT,
    output logic       SSPFSSOUT,
    output logic       SSPTXD,
    output logic       SSPOE_B,
    output logic       SSPTXINTR,
    output logic       SSPRXINTR
);

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic {RX_IDLE, RX_RECV}  rx_state_t;

    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [1:0]        tx_wptr;
    logic [1:0]        tx_rptr;
    logic [2:0]        tx_cnt;
    logic [2:0]        tx_cnt_nxt;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_tick;

    tx_state_t         tx_state;
    logic [2:0]        tx_idx;
    logic [DATA_W-1:0] tx_shreg;

    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [1:0]        rx_wptr;
    logic [1:0]        rx_rptr;
    logic [2:0]        rx_cnt;
    logic [2:0]        rx_cnt_nxt;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_pop;

    logic              clkin_p0;
    logic              clkin_p1;
    logic              fss_p0;
    logic              rxd_p0;
    logic              rx_fall;
    rx_state_t         rx_state;
    logic [2:0]        rx_bits;
    logic [6:0]        rx_shreg;
    logic [DATA_W-1:0] rx_word;

    // Full is judged on the registered count, so a write to a full FIFO is
    // dropped even when the transmitter frees a slot on the same edge.
    assign tx_full  = (tx_cnt == 3'd4);
    assign tx_empty = (tx_cnt == 3'd0);
    assign tx_push  = PSEL && PWRITE && !tx_full;
    assign tx_tick  = !SSPCLKOUT;
    assign tx_pop   = tx_tick && !tx_empty &&
                      ((tx_state == TX_IDLE) || (tx_idx == 3'd0));

    always_comb begin
        tx_cnt_nxt = tx_cnt;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_nxt = tx_cnt + 3'd1;
            2'b01:   tx_cnt_nxt = tx_cnt - 3'd1;
            default: tx_cnt_nxt = tx_cnt;
        endcase
    end

    always_ff @(posedge PCLK or posedge CLEAR_B) begin
        if (CLEAR_B) begin
            tx_wptr   <= 2'd0;
            tx_rptr   <= 2'd0;
            tx_cnt    <= 3'd0;
            SSPTXINTR <= 1'b0;
        end else begin
            if (tx_push)
                tx_wptr <= tx_wptr + 2'd1;
            if (tx_pop)
                tx_rptr <= tx_rptr + 2'd1;
            tx_cnt    <= tx_cnt_nxt;
            SSPTXINTR <= (tx_cnt_nxt == 3'd4);
        end
    end

    always_ff @(posedge PCLK) begin
        if (tx_push)
            tx_mem[tx_wptr] <= PWDATA;
        if (tx_pop)
            tx_shreg <= tx_mem[tx_rptr];
    end

    // Transmit FSM: every output moves only on the 0->1 edge of SSPCLKOUT.
    always_ff @(posedge PCLK or posedge CLEAR_B) begin
        if (CLEAR_B) begin
            SSPCLKOUT <= 1'b0;
            SSPFSSOUT <= 1'b0;
            SSPTXD    <= 1'b0;
            SSPOE_B   <= 1'b1;
            tx_state  <= TX_IDLE;
            tx_idx    <= 3'd7;
        end else begin
            SSPCLKOUT <= ~SSPCLKOUT;
            if (tx_tick) begin
                case (tx_state)
                    TX_IDLE: begin
                        SSPTXD    <= 1'b0;
                        SSPOE_B   <= 1'b1;
                        SSPFSSOUT <= !tx_empty;
                        tx_idx    <= 3'd7;
                        if (!tx_empty)
                            tx_state <= TX_SHIFT;
                    end
                    TX_SHIFT: begin
                        SSPTXD    <= tx_shreg[tx_idx];
                        SSPOE_B   <= 1'b0;
                        SSPFSSOUT <= 1'b0;
                        // idx wraps 0->7 so a back-to-back frame starts at its MSB
                        tx_idx    <= tx_idx - 3'd1;
                        if (tx_idx == 3'd0) begin
                            if (!tx_empty)
                                SSPFSSOUT <= 1'b1;
                            else
                                tx_state <= TX_IDLE;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // Input sampling stage: clock, frame and data share one register delay
    // so the data bit lines up with the detected falling edge.
    always_ff @(posedge PCLK or posedge CLEAR_B) begin
        if (CLEAR_B) begin
            clkin_p0 <= 1'b0;
            clkin_p1 <= 1'b0;
            fss_p0   <= 1'b0;
        end else begin
            clkin_p0 <= SSPCLKIN;
            clkin_p1 <= clkin_p0;
            fss_p0   <= SSPFSSIN;
        end
    end

    always_ff @(posedge PCLK) begin
        rxd_p0 <= SSPRXD;
    end

    assign rx_fall  = clkin_p1 && !clkin_p0;
    assign rx_word  = {rx_shreg, rxd_p0};
    assign rx_full  = (rx_cnt == 3'd4);
    assign rx_empty = (rx_cnt == 3'd0);
    assign rx_push  = rx_fall && (rx_state == RX_RECV) && (rx_bits == 3'd7) && !rx_full;
    assign rx_pop   = PSEL && !PWRITE && !rx_empty;

    always_ff @(posedge PCLK or posedge CLEAR_B) begin
        if (CLEAR_B) begin
            rx_state <= RX_IDLE;
            rx_bits  <= 3'd0;
        end else if (rx_fall) begin
            case (rx_state)
                RX_IDLE: begin
                    rx_bits <= 3'd0;
                    if (fss_p0)
                        rx_state <= RX_RECV;
                end
                RX_RECV: begin
                    rx_bits <= rx_bits + 3'd1;
                    if (rx_bits == 3'd7)
                        rx_state <= fss_p0 ? RX_RECV : RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (rx_fall && (rx_state == RX_RECV))
            rx_shreg <= rx_word[6:0];
        if (rx_push)
            rx_mem[rx_wptr] <= rx_word;
    end

    always_comb begin
        rx_cnt_nxt = rx_cnt;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_nxt = rx_cnt + 3'd1;
            2'b01:   rx_cnt_nxt = rx_cnt - 3'd1;
            default: rx_cnt_nxt = rx_cnt;
        endcase
    end

    always_ff @(posedge PCLK or posedge CLEAR_B) begin
        if (CLEAR_B) begin
            rx_wptr   <= 2'd0;
            rx_rptr   <= 2'd0;
            rx_cnt    <= 3'd0;
            SSPRXINTR <= 1'b0;
            PRDATA    <= 8'h00;
        end else begin
            if (rx_push)
                rx_wptr <= rx_wptr + 2'd1;
            if (rx_pop) begin
                rx_rptr <= rx_rptr + 2'd1;
                PRDATA  <= rx_mem[rx_rptr];
            end
            rx_cnt    <= rx_cnt_nxt;
            SSPRXINTR <= (rx_cnt_nxt == 3'd4);
        end
    end

endmodule

// File: tb/tb_ssp.sv
// Scoreboard bench for ssp: a serial-line monitor decodes transmitted frames and
// a bus monitor checks read data, both against queues filled by the stimulus.
`timescale 1ns/1ps
module tb_ssp;

    logic       PCLK    = 1'b0;
    logic       CLEAR_B = 1'b1;
    logic       PSEL    = 1'b1;
    logic       PWRITE  = 1'b1;
    logic [7:0] PWDATA  = 8'hFF;
    logic [7:0] PRDATA;
    logic       SSPCLKIN;
    logic       SSPFSSIN;
    logic       SSPRXD;
    logic       SSPCLKOUT;
    logic       SSPFSSOUT;
    logic       SSPTXD;
    logic       SSPOE_B;
    logic       SSPTXINTR;
    logic       SSPRXINTR;

    logic loop      = 1'b0;
    logic clkin_drv = 1'b0;
    logic fssin_drv = 1'b0;
    logic rxd_drv   = 1'b0;

    assign SSPCLKIN = loop ? SSPCLKOUT : clkin_drv;
    assign SSPFSSIN = loop ? SSPFSSOUT : fssin_drv;
    assign SSPRXD   = loop ? SSPTXD    : rxd_drv;

    ssp dut (
        .PCLK      (PCLK),
        .CLEAR_B   (CLEAR_B),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .SSPCLKIN  (SSPCLKIN),
        .SSPFSSIN  (SSPFSSIN),
        .SSPRXD    (SSPRXD),
        .SSPCLKOUT (SSPCLKOUT),
        .SSPFSSOUT (SSPFSSOUT),
        .SSPTXD    (SSPTXD),
        .SSPOE_B   (SSPOE_B),
        .SSPTXINTR (SSPTXINTR),
        .SSPRXINTR (SSPRXINTR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0] w;
        logic       fe;   // SSPFSSOUT required on this word's bit-0 tick
    } txe_t;

    txe_t       txq[$];
    logic [7:0] rdq[$];
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         fss_seen = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
        end
    endtask

    task automatic exp_tx(input logic [7:0] w, input logic fe);
        txe_t e;
        e.w  = w;
        e.fe = fe;
        txq.push_back(e);
    endtask

    task automatic bus_write(input logic [7:0] d);
        @(negedge PCLK);
        PSEL   = 1'b1;
        PWRITE = 1'b1;
        PWDATA = d;
    endtask

    task automatic bus_idle();
        @(negedge PCLK);
        PSEL   = 1'b0;
        PWRITE = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] exp);
        @(negedge PCLK);
        PSEL   = 1'b1;
        PWRITE = 1'b0;
        rdq.push_back(exp);
        @(negedge PCLK);
        PSEL   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        i = 0;
        while ((txq.size() != 0 || SSPOE_B !== 1'b1) && i < budget) begin
            @(negedge PCLK);
            i++;
        end
        check(name, 8'(i >= budget), 8'h00);
    endtask

    // Serial monitor: decode frames on every TX tick (SSPCLKOUT 0->1).
    initial begin : tx_mon
        logic       prev_clk;
        logic       in_frame;
        int         nbits;
        logic [7:0] word;
        txe_t       e;
        prev_clk = 1'b0;
        in_frame = 1'b0;
        nbits    = 0;
        word     = 8'h00;
        forever begin
            @(negedge PCLK);
            if (CLEAR_B) begin
                in_frame = 1'b0;
                nbits    = 0;
            end else if (SSPCLKOUT && !prev_clk) begin
                if (!SSPOE_B) begin
                    if (!in_frame) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_stray_bit: SSPOE_B=0 outside a frame, required 1");
                    end else begin
                        word = {word[6:0], SSPTXD};
                        nbits++;
                        if (nbits == 8) begin
                            if (txq.size() == 0) begin
                                n_tests++;
                                n_fail++;
                                $display("FAIL tx_unexpected: got word 0x%02h, required none", word);
                            end else begin
                                e = txq.pop_front();
                                check("tx_word", word, e.w);
                                check("tx_fss_at_bit0", 8'(SSPFSSOUT), 8'(e.fe));
                            end
                            nbits    = 0;
                            in_frame = 1'b0;
                        end
                    end
                end else if (in_frame) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_gap: SSPOE_B=1 mid-frame after %0d bits, required 0", nbits);
                end
                if (SSPFSSOUT) begin
                    in_frame = 1'b1;
                    nbits    = 0;
                    fss_seen++;
                end
            end
            prev_clk = SSPCLKOUT;
        end
    end

    // Bus monitor: a read accepted on a rising edge is checked on the next falling edge.
    initial begin : rd_mon
        logic hit;
        forever begin
            @(posedge PCLK);
            hit = PSEL && !PWRITE && !CLEAR_B;
            @(negedge PCLK);
            if (hit) begin
                if (rdq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got PRDATA 0x%02h, required no read", PRDATA);
                end else begin
                    check("prdata", PRDATA, rdq.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;

        // Reset held with a write pending on the bus
        cycles(4);
        check("rst_prdata", PRDATA, 8'h00);
        check("rst_clkout", 8'(SSPCLKOUT), 8'h00);
        check("rst_fssout", 8'(SSPFSSOUT), 8'h00);
        check("rst_txd",    8'(SSPTXD),    8'h00);
        check("rst_oe_b",   8'(SSPOE_B),   8'h01);
        check("rst_txintr", 8'(SSPTXINTR), 8'h00);
        check("rst_rxintr", 8'(SSPRXINTR), 8'h00);
        @(negedge PCLK);
        CLEAR_B = 1'b0;
        PSEL    = 1'b0;
        PWRITE  = 1'b0;
        base    = fss_seen;
        cycles(30);
        check("rst_no_push", 8'(fss_seen - base), 8'h00);
        check("rst_oe_idle", 8'(SSPOE_B), 8'h01);
        bus_read(8'h00);

        // Writes with PSEL low are ignored
        @(negedge PCLK);
        PSEL   = 1'b0;
        PWRITE = 1'b1;
        PWDATA = 8'h77;
        cycles(3);
        PWRITE = 1'b0;
        base   = fss_seen;
        cycles(30);
        check("psel0_ignored", 8'(fss_seen - base), 8'h00);

        // Single word
        exp_tx(8'h35, 1'b0);
        bus_write(8'h35);
        bus_idle();
        wait_drain("single_drain", 100);
        check("single_txd_idle", 8'(SSPTXD), 8'h00);
        check("single_fss_idle", 8'(SSPFSSOUT), 8'h00);

        // Back-to-back frames
        exp_tx(8'h35, 1'b1);
        exp_tx(8'hAE, 1'b0);
        bus_write(8'h35);
        bus_write(8'hAE);
        bus_idle();
        wait_drain("b2b_drain", 150);

        // TX FIFO full: 0x26 leaves for the shifter early, so 0x8F fits; 0xB1 and 0x55 drop
        exp_tx(8'h26, 1'b1);
        exp_tx(8'h39, 1'b1);
        exp_tx(8'h9D, 1'b1);
        exp_tx(8'h74, 1'b1);
        exp_tx(8'h8F, 1'b0);
        bus_write(8'h26);
        bus_write(8'h39);
        bus_write(8'h9D);
        bus_write(8'h74);
        bus_write(8'h8F);
        bus_write(8'hB1);
        bus_write(8'h55);
        bus_idle();
        check("txfull_intr_set", 8'(SSPTXINTR), 8'h01);
        cycles(20);
        check("txfull_intr_clr", 8'(SSPTXINTR), 8'h00);
        wait_drain("txfull_drain", 300);

        // Reset mid-frame discards the frame in flight and the queued word
        bus_write(8'h5A);
        bus_write(8'hA5);
        bus_idle();
        cycles(6);
        CLEAR_B = 1'b1;
        cycles(2);
        check("abort_oe_b",   8'(SSPOE_B),   8'h01);
        check("abort_fssout", 8'(SSPFSSOUT), 8'h00);
        check("abort_clkout", 8'(SSPCLKOUT), 8'h00);
        @(negedge PCLK);
        CLEAR_B = 1'b0;
        base    = fss_seen;
        cycles(40);
        check("abort_fifo_lost", 8'(fss_seen - base), 8'h00);

        // Loopback single word
        loop = 1'b1;
        cycles(4);
        exp_tx(8'hAE, 1'b0);
        bus_write(8'hAE);
        bus_idle();
        wait_drain("loop_drain", 100);
        cycles(6);
        bus_read(8'hAE);
        check("loop_rxintr", 8'(SSPRXINTR), 8'h00);
        bus_read(8'hAE);

        // Loopback RX FIFO overflow: fifth word discarded
        exp_tx(8'h11, 1'b1);
        exp_tx(8'h22, 1'b1);
        exp_tx(8'h33, 1'b1);
        exp_tx(8'h44, 1'b1);
        exp_tx(8'h55, 1'b0);
        bus_write(8'h11);
        bus_write(8'h22);
        bus_write(8'h33);
        bus_write(8'h44);
        bus_write(8'h55);
        bus_idle();
        wait_drain("rxfull_drain", 400);
        cycles(6);
        check("rxfull_intr_set", 8'(SSPRXINTR), 8'h01);
        bus_read(8'h11);
        check("rxfull_intr_clr", 8'(SSPRXINTR), 8'h00);
        bus_read(8'h22);
        bus_read(8'h33);
        bus_read(8'h44);
        bus_read(8'h44);

        cycles(4);
        check("rd_pending", 8'(rdq.size()), 8'h00);
        check("tx_pending", 8'(txq.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ssp.md
Name: ssp

Overview:
- Synchronous serial port (TI synchronous-serial frame format) bridging an APB-style 8-bit write/read bus to a serial link.
- Words written from the bus are queued in a 4-deep TX FIFO and shifted out MSB-first with a frame-sync pulse.
- Serial frames received on the input pins are assembled into a 4-deep RX FIFO that the bus reads back.
- Sits between the peripheral bus and off-chip serial pins; master clock/frame are generated from PCLK.

Parameters:
- none (data width fixed at 8, FIFO depths fixed at 4)

Ports:
- PCLK  input  1  system clock; every flop is clocked on its rising edge.
- CLEAR_B  input  1  reset, asynchronous and active-high; asserting it high immediately resets all state.
- PSEL  input  1  bus select.
- PWRITE  input  1  1 = write to TX FIFO, 0 = read from RX FIFO (qualified by PSEL).
- PWDATA  input  8  write data.
- PRDATA  output  8  read data (registered).
- SSPCLKIN  input  1  serial receive clock, sampled by PCLK.
- SSPFSSIN  input  1  receive frame sync, sampled by PCLK.
- SSPRXD  input  1  serial receive data, sampled by PCLK.
- SSPCLKOUT  output  1  serial transmit clock = PCLK/2.
- SSPFSSOUT  output  1  transmit frame sync.
- SSPTXD  output  1  serial transmit data.
- SSPOE_B  output  1  active-low output enable, low while a data bit is driven.
- SSPTXINTR  output  1  TX FIFO full.
- SSPRXINTR  output  1  RX FIFO full.

Behaviour:
- Reset values: PRDATA=0, SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, SSPTXINTR=0, SSPRXINTR=0. Both FIFOs empty, TX and RX FSMs idle.
- Bus write: on a PCLK edge with PSEL=1, PWRITE=1 and TX FIFO not full, PWDATA is pushed.
  - Full is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if the transmitter pops that cycle.
  - Writes while PSEL=0 are ignored.
  - One push per PCLK cycle while PSEL and PWRITE are held.
- Bus read: on a PCLK edge with PSEL=1, PWRITE=0 and RX FIFO not empty, PRDATA <= oldest word and that word is popped.
  - Reading an empty FIFO leaves PRDATA unchanged.
  - PRDATA otherwise holds its value.
- FIFOs: circular buffer, 2-bit pointers that wrap 3->0, full/empty tracked with a count (0..4).
  - Simultaneous push and pop are both honoured; the count is unchanged.
- SSPTXINTR = (TX count==4) and SSPRXINTR = (RX count==4), both registered from the count.
- SSPCLKOUT toggles on every PCLK edge after reset. A "TX tick" is a PCLK edge where SSPCLKOUT goes 0->1. All TX outputs change only on TX ticks.
- TX FSM states:
  - IDLE: on a TX tick with TX FIFO non-empty, pop the word into the shift register, set SSPFSSOUT=1, go to SHIFT with bit index 7.
  - SHIFT: on each TX tick drive SSPTXD = shreg[idx] with SSPOE_B=0 and SSPFSSOUT=0, then decrement idx.
  - Bit 0 tick, FIFO non-empty: pop the next word and set SSPFSSOUT=1 in the same tick. The next MSB follows with no gap (back-to-back frames).
  - Bit 0 tick, FIFO empty: the following tick returns to IDLE with SSPOE_B=1 and SSPTXD=0.
  - A frame is 1 FSS tick plus 8 data ticks; SSPTXD holds each bit for 2 PCLK cycles.
- RX:
  - SSPCLKIN is registered; a falling edge is detected when prev=1 and cur=0.
  - On a detected falling edge in RX IDLE with SSPFSSIN=1, arm reception.
  - The next 8 falling edges shift SSPRXD in, MSB first.
  - After the 8th bit, the word is pushed into the RX FIFO; if the FIFO is full the word is discarded.
  - FSSIN seen high on the 8th-bit edge re-arms immediately for a back-to-back frame.
- CLEAR_B asserted mid-frame aborts the transfer; FIFO contents are lost.

Test Plan:
- Reset: hold CLEAR_B=1 with PSEL=1, PWRITE=1, PWDATA=0xFF -> nothing pushed, all outputs at reset values, SSPOE_B=1.
- Single word: write 0x35 for one cycle -> one SSPFSSOUT tick, then SSPTXD = 0,0,1,1,0,1,0,1 on successive TX ticks with SSPOE_B=0 during those 8 ticks, then SSPOE_B=1.
- Back-to-back: write 0x35 then 0xAE on consecutive cycles -> the FSS pulse for 0xAE coincides with bit 0 of 0x35, then bits 1,0,1,0,1,1,1,0 with no idle tick.
- TX full: with PSEL held, write 0x26, 0x39, 0x9D, 0x74, 0x8F, 0xB1, 0x55 at one per cycle -> SSPTXINTR=1 once count hits 4, and excess writes are dropped. Transmitted sequence starts 0x26, 0x39, 0x9D, 0x74; SSPTXINTR clears after the next pop.
- Loopback: tie SSPCLKOUT->SSPCLKIN, SSPFSSOUT->SSPFSSIN, SSPTXD->SSPRXD; write 0xAE -> after the frame, a read returns PRDATA=0xAE and the RX FIFO is empty.
- RX full: loop back 5 words 0x11, 0x22, 0x33, 0x44, 0x55 without reading -> SSPRXINTR=1, and four reads return 0x11, 0x22, 0x33, 0x44 (0x55 dropped).
